// File: rtl/cordic_sincos.sv
// Iterative rotation-mode CORDIC sine/cosine with full-circle quadrant folding and valid/ready handshakes.
// Optional CORDIC_GAIN_COMP_EN: start vector pre-scaled by 1/K so results have unit magnitude.
module cordic_sincos #(
  parameter int WIDTH = 16,
  parameter int ITER  = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_angle,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sin,
  output logic [WIDTH-1:0] out_cos
);

  // Fractional guard bits below the output LSB keep shift/table rounding inside the accuracy budget.
  localparam int  GUARD = 6;
  localparam int  DW    = WIDTH + 2 + GUARD;
  localparam int  CW    = $clog2(ITER + 1);
  localparam real PI    = 3.14159265358979323846;
`ifdef CORDIC_GAIN_COMP_EN
  localparam int X0_BASE = $rtoi(0.6072529350 * (2.0 ** (WIDTH - 2)) + 0.5);
`else
  localparam int X0_BASE = 32'sd1 <<< (WIDTH - 2);
`endif
  localparam logic signed [DW-1:0] X0     = DW'(longint'(X0_BASE) <<< GUARD);
  localparam logic signed [DW-1:0] HALF   = DW'(64'sd1 <<< (GUARD - 1));
  localparam logic signed [DW-1:0] SAT_HI = DW'((64'sd1 <<< (WIDTH - 1)) - 64'sd1);
  localparam logic signed [DW-1:0] SAT_LO = ~SAT_HI;

  typedef enum logic [1:0] {IDLE = 2'd0, ROTATE = 2'd1, DONE = 2'd2} state_e;

  function automatic logic signed [DW-1:0] atan_entry(input int k);
    real a;
    a = $atan(1.0 / (2.0 ** k)) / (2.0 * PI) * (2.0 ** (WIDTH + GUARD));
    return DW'(longint'(a));
  endfunction

  function automatic logic [WIDTH-1:0] sat_round(input logic signed [DW-1:0] v);
    logic signed [DW-1:0] r;
    r = (v + HALF) >>> GUARD;
    if (r > SAT_HI) begin
      return {1'b0, {(WIDTH-1){1'b1}}};
    end else if (r < SAT_LO) begin
      return {1'b1, {(WIDTH-1){1'b0}}};
    end else begin
      return r[WIDTH-1:0];
    end
  endfunction

  logic signed [DW-1:0] atan_s [2**CW];
  for (genvar k = 0; k < 2**CW; k++) begin : g_atan
    if (k < ITER) begin : g_val
      assign atan_s[k] = atan_entry(k);
    end else begin : g_zero
      assign atan_s[k] = '0;
    end
  end

  state_e               state_q, state_d;
  logic signed [DW-1:0] x_q, x_d, y_q, y_d, z_q, z_d;
  logic signed [DW-1:0] x_rot_s, y_rot_s, z_rot_s;
  logic [CW-1:0]        iter_q, iter_d;
  logic [1:0]           quad_q, quad_d;
  logic [WIDTH-1:0]     sin_q, sin_d, cos_q, cos_d;
  logic                 in_ready_q, out_valid_q;

  // One micro-rotation toward z = 0.
  always_comb begin
    if (!z_q[DW-1]) begin
      x_rot_s = x_q - (y_q >>> iter_q);
      y_rot_s = y_q + (x_q >>> iter_q);
      z_rot_s = z_q - atan_s[iter_q];
    end else begin
      x_rot_s = x_q + (y_q >>> iter_q);
      y_rot_s = y_q - (x_q >>> iter_q);
      z_rot_s = z_q + atan_s[iter_q];
    end
  end

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    iter_d  = iter_q;
    quad_d  = quad_q;
    sin_d   = sin_q;
    cos_d   = cos_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          quad_d  = in_angle[WIDTH-1:WIDTH-2];
          z_d     = {2'b00, in_angle[WIDTH-3:0], {GUARD{1'b0}}};
          x_d     = X0;
          y_d     = '0;
          iter_d  = '0;
          state_d = ROTATE;
        end else begin
          state_d = IDLE;
        end
      end
      ROTATE: begin
        x_d    = x_rot_s;
        y_d    = y_rot_s;
        z_d    = z_rot_s;
        iter_d = iter_q + CW'(1);
        if (iter_q == CW'(ITER - 1)) begin
          state_d = DONE;
          // Fold the first-quadrant result back onto the full circle.
          case (quad_q)
            2'd0: begin sin_d = sat_round(y_rot_s);  cos_d = sat_round(x_rot_s);  end
            2'd1: begin sin_d = sat_round(x_rot_s);  cos_d = sat_round(-y_rot_s); end
            2'd2: begin sin_d = sat_round(-y_rot_s); cos_d = sat_round(-x_rot_s); end
            default: begin sin_d = sat_round(-x_rot_s); cos_d = sat_round(y_rot_s); end
          endcase
        end else begin
          state_d = ROTATE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, datapath and registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      x_q         <= '0;
      y_q         <= '0;
      z_q         <= '0;
      iter_q      <= '0;
      quad_q      <= 2'd0;
      sin_q       <= '0;
      cos_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      z_q         <= z_d;
      iter_q      <= iter_d;
      quad_q      <= quad_d;
      sin_q       <= sin_d;
      cos_q       <= cos_d;
      in_ready_q  <= (state_d == IDLE);
      out_valid_q <= (state_d == DONE);
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_sin   = sin_q;
  assign out_cos   = cos_q;

endmodule

// File: tb/tb_cordic_sincos.sv
// Directed plus randomized bench for cordic_sincos against a trigonometric reference model.
// Expectations follow CORDIC_GAIN_COMP_EN: unit magnitude when defined, CORDIC gain otherwise.
module tb_cordic_sincos;
  localparam int  W  = 16;
  localparam int  IT = 14;
  localparam real PI = 3.14159265358979323846;

  logic                clk = 1'b0;
  logic                rst;
  logic                in_valid;
  logic                in_ready;
  logic [W-1:0]        in_angle;
  logic                out_valid;
  logic                out_ready;
  logic signed [W-1:0] out_sin;
  logic signed [W-1:0] out_cos;

  int  checks = 0;
  int  errors = 0;
  int  cyc    = 0;
  real scale;
  int  tol;

  cordic_sincos #(.WIDTH(W), .ITER(IT)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_angle  (in_angle),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sin   (out_sin),
    .out_cos   (out_cos)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int rnd(input real r);
    if (r >= 0.0) return $rtoi(r + 0.5);
    else return -$rtoi(0.5 - r);
  endfunction

  function automatic int ref_sin(input logic [W-1:0] a);
    return rnd(scale * $sin(2.0 * PI * real'(a) / (2.0 ** W)));
  endfunction

  function automatic int ref_cos(input logic [W-1:0] a);
    return rnd(scale * $cos(2.0 * PI * real'(a) / (2.0 ** W)));
  endfunction

  task automatic chk_eq(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_near(input string tag, input int obs, input int exp);
    checks++;
    assert ((obs - exp) <= tol && (exp - obs) <= tol) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d +/- %0d", tag, obs, exp, tol);
    end
  endtask

  // Accept one angle, scramble in_angle afterwards, and wait (bounded) for out_valid.
  task automatic request(input logic [W-1:0] ang, input logic hold_valid,
                         output int lat, output int acc_at);
    int n;
    n = 0;
    while (in_ready !== 1'b1 && n < 64) begin
      @(posedge clk); @(negedge clk); n++;
    end
    in_angle = ang;
    in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    acc_at   = cyc;
    in_valid = hold_valid;
    in_angle = W'($urandom);
    n = 0;
    while (out_valid !== 1'b1 && n < 64) begin
      @(posedge clk); @(negedge clk); n++;
    end
    lat = n;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
    chk_eq("valid_drop", out_valid, 0);
    chk_eq("ready_back", in_ready, 1);
  endtask

  initial begin
    logic [W-1:0] dir_ang [7];
    logic [W-1:0] a;
    logic [W-1:0] s0, c0;
    int lat, acc, prev_acc, bad;
    real k;

    k = 1.0;
    for (int i = 0; i < IT; i++) k = k * $sqrt(1.0 + 1.0 / (4.0 ** i));
`ifdef CORDIC_GAIN_COMP_EN
    scale = 2.0 ** (W - 2);
    tol   = 4;
`else
    scale = (2.0 ** (W - 2)) * k;
    tol   = 6;
`endif

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_angle = '0;
    repeat (3) @(negedge clk);
    chk_eq("rst_in_ready", in_ready, 1);
    chk_eq("rst_out_valid", out_valid, 0);
    chk_eq("rst_sin", out_sin, 0);
    chk_eq("rst_cos", out_cos, 0);
    rst = 1'b0;
    @(negedge clk);

    dir_ang[0] = 16'h0000; dir_ang[1] = 16'h2000; dir_ang[2] = 16'h4000;
    dir_ang[3] = 16'hC000; dir_ang[4] = 16'h8000; dir_ang[5] = 16'hFFFF;
    dir_ang[6] = 16'h3FFF;
    for (int i = 0; i < 7; i++) begin
      request(dir_ang[i], 1'b0, lat, acc);
      chk_eq("latency", lat, IT);
      chk_near($sformatf("sin_%h", dir_ang[i]), int'(out_sin), ref_sin(dir_ang[i]));
      chk_near($sformatf("cos_%h", dir_ang[i]), int'(out_cos), ref_cos(dir_ang[i]));
      consume();
    end

    // Stall in DONE while the source keeps offering 0x1000.
    request(16'h6000, 1'b0, lat, acc);
    s0 = out_sin; c0 = out_cos;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      in_valid = (i % 2 == 0);
      in_angle = 16'h1000;
      @(posedge clk); @(negedge clk);
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_sin !== s0 || out_cos !== c0) bad++;
    end
    in_valid = 1'b0;
    chk_eq("stall_hold", bad, 0);
    chk_near("stall_sin", int'(out_sin), ref_sin(16'h6000));
    chk_near("stall_cos", int'(out_cos), ref_cos(16'h6000));
    consume();

    // Reset in the middle of a rotation.
    in_angle = 16'h4000;
    in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    repeat (7) begin @(posedge clk); @(negedge clk); end
    rst = 1'b1;
    #1;
    chk_eq("midrst_in_ready", in_ready, 1);
    chk_eq("midrst_out_valid", out_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); @(negedge clk);
      if (out_valid !== 1'b0) bad++;
    end
    chk_eq("midrst_no_valid", bad, 0);
    request(16'h0000, 1'b0, lat, acc);
    chk_eq("postrst_latency", lat, IT);
    chk_near("postrst_cos", int'(out_cos), ref_cos(16'h0000));
    chk_near("postrst_sin", int'(out_sin), ref_sin(16'h0000));
    consume();

    // Back-to-back random sweep with out_ready tied high.
    out_ready = 1'b1;
    prev_acc  = 0;
    for (int n = 0; n < 4096; n++) begin
      a = W'($urandom);
      request(a, 1'b1, lat, acc);
      if (n > 0) chk_eq("spacing", acc - prev_acc, IT + 2);
      prev_acc = acc;
      chk_near($sformatf("sweep_sin_%h", a), int'(out_sin), ref_sin(a));
      chk_near($sformatf("sweep_cos_%h", a), int'(out_cos), ref_cos(a));
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
